// File: rtl/div_issue_ctrl.sv
// Divide issue/writeback controller: accepts M-extension div ops, resolves div-by-zero and signed overflow locally, else drives the divider.
// Latency: special cases give out_valid 1 cycle after accept; divider ops give out_valid 1 cycle after the rising edge of div_done.
// Backpressure: in_ready is low whenever an op is in flight; the result is held in RESP until out_valid & out_ready.
//
// Ports:
//   clk, clr              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     op handshake from execute; in_func3 (00 DIV, 01 DIVU, 10 REM, 11 REMU), in_rs1, in_rs2, in_rd_addr
//   flush                 kill the in-flight op, no result is produced
//   div_go                one-cycle start pulse; div_func3/div_rs1/div_rs2 registered operands
//   div_done/div_rd       divider completion level (rising edge honoured) and result
//   out_valid/out_ready   result handshake to writeback; out_data, out_rd_addr
//   busy                  controller not idle
//   timeout_err           sticky divider watchdog flag, cleared only by clr
module div_issue_ctrl #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      in_func3,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [4:0]      in_rd_addr,
   input  logic            flush,
   output logic            div_go,
   output logic [1:0]      div_func3,
   output logic [XLEN-1:0] div_rs1,
   output logic [XLEN-1:0] div_rs2,
   input  logic            div_done,
   input  logic [XLEN-1:0] div_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_data,
   output logic [4:0]      out_rd_addr,
   output logic            busy,
   output logic            timeout_err
);

   localparam int            CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DRAIN,
      S_RESP
   } state_t;

   state_t          state;
   logic            done_q;
   logic [CW-1:0]   cnt;

   logic            accept;
   logic            done_rise;
   logic [CW-1:0]   cnt_inc;
   logic            is_zero;
   logic            is_ovf;
   logic [XLEN-1:0] special_res;
   logic            deliver;

   assign in_ready  = (state == S_IDLE) & ~flush;
   assign accept    = in_valid & in_ready;
   assign busy      = (state != S_IDLE);
   // Only a fresh edge counts: a done level left high from an earlier op never completes a new one.
   assign done_rise = div_done & ~done_q;
   assign cnt_inc   = cnt + CW'(1);

   assign is_zero = (in_rs2 == '0);
   assign is_ovf  = ~in_func3[0] & (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (in_rs2 == '1);

   // RISC-V defined results for the cases the divider is never asked to compute.
   always_comb begin
      special_res = '0;
      if (is_zero)
         special_res = in_func3[1] ? in_rs1 : '1;
      else if (is_ovf)
         special_res = in_func3[1] ? '0 : in_rs1;
   end

   // A flushed op (WAIT with flush, or DRAIN) still runs the divider to completion but produces no result.
   assign deliver = (state == S_WAIT) & ~flush;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state       <= S_IDLE;
         done_q      <= 1'b0;
         cnt         <= '0;
         div_go      <= 1'b0;
         div_func3   <= '0;
         div_rs1     <= '0;
         div_rs2     <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_rd_addr <= '0;
         timeout_err <= 1'b0;
      end else begin
         done_q <= div_done;
         div_go <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  div_func3   <= in_func3;
                  div_rs1     <= in_rs1;
                  div_rs2     <= in_rs2;
                  out_rd_addr <= in_rd_addr;
                  if (is_zero | is_ovf) begin
                     out_data  <= special_res;
                     out_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     // go is high for exactly the LAUNCH cycle.
                     div_go <= 1'b1;
                     state  <= S_LAUNCH;
                  end
               end
            end
            S_LAUNCH: begin
               cnt   <= '0;
               state <= flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT, S_DRAIN: begin
               if (done_rise) begin
                  if (deliver) begin
                     out_data  <= div_rd;
                     out_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (cnt_inc == CNT_MAX) begin
                  timeout_err <= 1'b1;
                  if (deliver) begin
                     out_data  <= '0;
                     out_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt_inc;
                  if (flush)
                     state <= S_DRAIN;
               end
            end
            S_RESP: begin
               if (flush | out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

   logic        clk = 1'b0;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_func3;
   logic [31:0] in_rs1;
   logic [31:0] in_rs2;
   logic [4:0]  in_rd_addr;
   logic        flush;
   logic        div_go;
   logic [1:0]  div_func3;
   logic [31:0] div_rs1;
   logic [31:0] div_rs2;
   logic        div_done;
   logic [31:0] div_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [4:0]  out_rd_addr;
   logic        busy;
   logic        timeout_err;

   int n_assert = 0;
   int n_fail   = 0;
   int go_cnt   = 0;

   div_issue_ctrl #(.XLEN(32), .TIMEOUT_CYCLES(64)) dut (
      .clk         (clk),
      .clr         (clr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_func3    (in_func3),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_rd_addr  (in_rd_addr),
      .flush       (flush),
      .div_go      (div_go),
      .div_func3   (div_func3),
      .div_rs1     (div_rs1),
      .div_rs2     (div_rs2),
      .div_done    (div_done),
      .div_rd      (div_rd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_rd_addr (out_rd_addr),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   // Architectural result of an M-extension divide/remainder.
   function automatic logic [31:0] ref_res(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
      case (f)
         2'd0:    return sa / sb;
         2'd1:    return a / b;
         2'd2:    return sa % sb;
         default: return a % b;
      endcase
   endfunction

   function automatic bit is_special(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   task automatic tick();
      @(negedge clk);
      if (div_go === 1'b1) go_cnt++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // One complete op: offer, (divider responds lat cycles after go), hold RESP for hold cycles, consume.
   task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int lat, input int hold);
      logic [31:0] exp;
      bit          spec;
      int          g0;
      exp  = ref_res(f, a, b);
      spec = is_special(f, a, b);
      in_valid   = 1'b1;
      in_func3   = f;
      in_rs1     = a;
      in_rs2     = b;
      in_rd_addr = rd;
      chk("in_ready_idle", in_ready, 1);
      g0 = go_cnt;
      tick();
      in_valid = 1'b0;
      in_rs1   = $urandom;
      in_rs2   = $urandom;
      if (!spec) begin
         chk("go_pulse", div_go, 1);
         chk("div_func3", div_func3, f);
         chk("div_rs1", div_rs1, a);
         chk("div_rs2", div_rs2, b);
         for (int i = 1; i < lat; i++) tick();
         chk("no_early_valid", out_valid, 0);
         div_rd   = exp;
         div_done = 1'b1;
         tick();
      end
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp);
      chk("out_rd_addr", out_rd_addr, rd);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, exp);
         chk("hold_busy", busy, 1);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      div_done  = 1'b0;
      chk("consumed_valid", out_valid, 0);
      chk("consumed_busy", busy, 0);
      chk("go_count", go_cnt - g0, spec ? 0 : 1);
   endtask

   initial begin
      logic [1:0]  rf;
      logic [31:0] ra;
      logic [31:0] rb;
      int          k;
      int          g0;

      clr        = 1'b1;
      in_valid   = 1'b0;
      in_func3   = 2'd0;
      in_rs1     = 32'd0;
      in_rs2     = 32'd0;
      in_rd_addr = 5'd0;
      flush      = 1'b0;
      div_done   = 1'b0;
      div_rd     = 32'd0;
      out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_div_go", div_go, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_out_data", out_data, 0);
      clr = 1'b0;
      tick();
      chk("idle_in_ready", in_ready, 1);

      // Directed functional ops
      run_op(2'd1, 32'd1000000, 32'd10, 5'd5, 34, 0);
      chk("divu_value", out_data, 32'd100000);
      run_op(2'd2, -32'sd33, 32'd8, 5'd7, 12, 3);
      chk("rem_value", out_data, 32'hFFFF_FFFF);
      run_op(2'd0, 32'd32, -32'sd2, 5'd8, 5, 0);
      chk("div_value", out_data, 32'hFFFF_FFF0);

      // Special cases
      run_op(2'd0, 32'd5, 32'd0, 5'd1, 1, 1);
      run_op(2'd3, 32'd7, 32'd0, 5'd2, 1, 1);
      run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1, 1);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1, 1);

      // Backpressure
      run_op(2'd1, 32'd12345, 32'd17, 5'd30, 9, 10);

      // Flush while in RESP
      in_valid = 1'b1; in_func3 = 2'd0; in_rs1 = 32'd5; in_rs2 = 32'd0; in_rd_addr = 5'd6;
      tick();
      in_valid = 1'b0;
      chk("fresp_valid", out_valid, 1);
      flush = 1'b1;
      chk("flush_blocks_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      chk("fresp_dropped", out_valid, 0);
      chk("fresp_idle", busy, 0);

      // Flush during WAIT, then a stale-high done on the next op
      g0 = go_cnt;
      in_valid = 1'b1; in_func3 = 2'd1; in_rs1 = 32'd100; in_rs2 = 32'd7; in_rd_addr = 5'd11;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("drain_in_ready", in_ready, 0);
         chk("drain_no_valid", out_valid, 0);
      end
      div_rd   = 32'd14;
      div_done = 1'b1;
      tick();
      chk("drain_end_valid", out_valid, 0);
      chk("drain_end_ready", in_ready, 1);
      chk("drain_go_count", go_cnt - g0, 1);
      in_valid = 1'b1; in_func3 = 2'd0; in_rs1 = 32'd100; in_rs2 = 32'hFFFF_FFF9; in_rd_addr = 5'd12;
      tick();
      in_valid = 1'b0;
      chk("stale_go", div_go, 1);
      repeat (5) tick();
      chk("stale_done_ignored", out_valid, 0);
      div_done = 1'b0;
      tick();
      div_rd   = ref_res(2'd0, 32'd100, 32'hFFFF_FFF9);
      div_done = 1'b1;
      tick();
      chk("stale_op_valid", out_valid, 1);
      chk("stale_op_data", out_data, 32'hFFFF_FFF2);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      div_done  = 1'b0;

      // Randomized ops against the reference model
      for (int n = 0; n < 20; n++) begin
         rf = 2'($urandom_range(0, 3));
         k  = $urandom_range(0, 9);
         if (k == 0) begin
            ra = $urandom; rb = 32'd0;
         end else if (k == 1) begin
            ra = 32'h8000_0000; rb = 32'hFFFF_FFFF;
         end else begin
            ra = $urandom; rb = $urandom >> $urandom_range(0, 31);
         end
         run_op(rf, ra, rb, 5'($urandom), $urandom_range(1, 40), $urandom_range(0, 3));
      end
      chk("no_timeout_yet", timeout_err, 0);

      // Watchdog
      in_valid = 1'b1; in_func3 = 2'd1; in_rs1 = 32'd9; in_rs2 = 32'd3; in_rd_addr = 5'd9;
      tick();
      in_valid = 1'b0;
      chk("wd_go", div_go, 1);
      k = 0;
      while (out_valid !== 1'b1 && k < 200) begin
         tick();
         k++;
      end
      chk("wd_latency", k, 65);
      chk("wd_err", timeout_err, 1);
      chk("wd_data", out_data, 0);
      chk("wd_rd", out_rd_addr, 5'd9);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("wd_sticky", timeout_err, 1);

      // Asynchronous reset in the middle of WAIT
      in_valid = 1'b1; in_func3 = 2'd0; in_rs1 = 32'd77; in_rs2 = 32'd5; in_rd_addr = 5'd13;
      tick();
      in_valid = 1'b0;
      repeat (10) tick();
      chk("pre_clr_busy", busy, 1);
      clr = 1'b1;
      #1;
      chk("clr_busy", busy, 0);
      chk("clr_err", timeout_err, 0);
      chk("clr_valid", out_valid, 0);
      chk("clr_data", out_data, 0);
      chk("clr_rd", out_rd_addr, 0);
      chk("clr_div_rs1", div_rs1, 0);
      chk("clr_div_rs2", div_rs2, 0);
      chk("clr_div_func3", div_func3, 0);
      chk("clr_go", div_go, 0);
      @(negedge clk);
      clr = 1'b0;
      tick();
      chk("post_clr_ready", in_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Issue/writeback controller between the execute stage and the divider wrapper (clk, go, clr, func3, rs1, rs2, done, rd).
- Accepts decoded M-extension divide ops over a valid/ready handshake and resolves the RISC-V corner cases locally: divide-by-zero and signed overflow.
- Launches the divider with a one-cycle go pulse, waits for done, and returns the result to writeback with a valid/ready handshake.
- Handles pipeline flush and a divider watchdog.

Parameters:
- XLEN, 32: operand/result width.
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before the watchdog fires; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- in_valid  in  1  op offered by execute.
- in_ready  out  1  op accepted when in_valid & in_ready.
- in_func3  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- in_rs1  in  XLEN  dividend.
- in_rs2  in  XLEN  divisor.
- in_rd_addr  in  5  destination register index.
- flush  in  1  kill the in-flight op; no result is produced.
- div_go  out  1  one-cycle start pulse to the divider.
- div_func3  out  2  registered func3.
- div_rs1  out  XLEN  registered dividend.
- div_rs2  out  XLEN  registered divisor.
- div_done  in  1  divider done (level; the rising edge marks completion).
- div_rd  in  XLEN  divider result, valid when div_done rises.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts.
- out_data  out  XLEN  result.
- out_rd_addr  out  5  destination index.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (clr=1, async): state=IDLE; every output register and the operand registers are 0; timeout_err=0; done_q=0. Mid-operation reset drops the op silently. div_go is 0 during reset.
- Edge detect: done_q<=div_done every cycle. done_rise = div_done & ~done_q. Only done_rise is honoured, and only in WAIT or DRAIN. A done that is already high at accept time is ignored.
- in_ready = (state==IDLE) & ~flush.
- Accept:
  - Register func3, rs1, rs2 and rd_addr.
  - Special cases are checked on the input values at accept.
  - Divide by zero (rs2==0): DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (func3 DIV or REM, rs1==0x80000000, rs2==0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - A special case goes straight to RESP, so out_valid is high the cycle after accept. div_go is never pulsed.
  - Otherwise go to LAUNCH.
- LAUNCH (1 cycle): div_go=1, with div_* driven from the registers. Next state is WAIT; the watchdog counter is cleared.
- WAIT:
  - Counter increments each cycle.
  - On done_rise: out_data<=div_rd, go to RESP.
  - If the counter reaches TIMEOUT_CYCLES without done_rise: timeout_err<=1, out_data<=0, go to RESP.
  - Normal latency: out_valid rises 1 cycle after the divider's done edge.
- RESP:
  - out_valid=1, with out_data and out_rd_addr held stable until out_valid & out_ready, then IDLE.
  - No new accept occurs in the same cycle.
- flush:
  - IDLE: no accept that cycle.
  - LAUNCH: div_go still pulses (the divider is already committed), then DRAIN.
  - WAIT: go to DRAIN.
  - DRAIN: wait for done_rise or timeout, then IDLE, with no out_valid. A timeout in DRAIN still sets timeout_err.
  - RESP: out_valid drops next cycle, go to IDLE.
  - flush has priority over out_ready and done_rise in the same cycle.
- States: IDLE, LAUNCH, WAIT, DRAIN, RESP (one-hot or binary).
- div_go is registered and glitch-free; there is never more than one go per accepted op.
- timeout_err is cleared only by clr.

Test Plan:
- DIVU 1000000/10, divider responds 34 cycles after go -> exactly one div_go; out_data=100000 one cycle after the done edge; out_rd_addr matches the input.
- REM -33,8 -> out_data=0xFFFFFFFF (-1). Back-to-back DIV 32,-2 -> out_data=0xFFFFFFF0 (-16). in_ready is low until the first result is consumed.
- Special cases, each with out_valid the cycle after accept and no div_go:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- Backpressure: hold out_ready=0 for 10 cycles in RESP -> out_data stays stable and busy stays 1. out_ready=1 -> IDLE next cycle.
- Flush during WAIT, then done rises -> no out_valid; in_ready stays 0 until the done edge, then returns to 1. A stale high done on the next op does not complete it early.
- Divider never asserts done with TIMEOUT_CYCLES=64 -> timeout_err=1 and out_valid with out_data=0 after 64 WAIT cycles. Assert clr mid-WAIT on a second op -> all outputs 0 immediately and timeout_err cleared.
